// File: rtl/stall_sched_pkg.sv
// ---------------------------------------------------------------------------
// stall_sched_pkg : shared stall-bus encodings and scheduler state codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stall_sched_pkg;

   localparam int STALL_BUS_W = 6;

   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   // bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB
   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_LOAD = 6'b000111;
   localparam stall_bus_t STALL_EX   = 6'b001111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/stall_sched_if.sv
// ---------------------------------------------------------------------------
// stall_sched_if : pipeline <-> hazard scheduler bundle
// Rev 1.0   (perf ports present when STALL_SCHED_PERF_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

interface stall_sched_if #(
   parameter int STALL_W = 6
);
   logic                stallreq_for_load;
   logic                div_req;
   logic                div_ready;
   logic                flush_req;
   logic [31:0]         flush_pc;
   logic [STALL_W-1:0]  stall;
   logic                flush;
   logic [31:0]         new_pc;
   logic                div_start;
   logic                div_cancel;
   logic                div_timeout;
`ifdef STALL_SCHED_PERF_EN
   logic [31:0]         perf_load_stall;
   logic [31:0]         perf_div_stall;
   logic [31:0]         perf_flush;

   modport master (
      output stallreq_for_load, div_req, div_ready, flush_req, flush_pc,
      input  stall, flush, new_pc, div_start, div_cancel, div_timeout,
      input  perf_load_stall, perf_div_stall, perf_flush
   );
   modport slave (
      input  stallreq_for_load, div_req, div_ready, flush_req, flush_pc,
      output stall, flush, new_pc, div_start, div_cancel, div_timeout,
      output perf_load_stall, perf_div_stall, perf_flush
   );
`else
   modport master (
      output stallreq_for_load, div_req, div_ready, flush_req, flush_pc,
      input  stall, flush, new_pc, div_start, div_cancel, div_timeout
   );
   modport slave (
      input  stallreq_for_load, div_req, div_ready, flush_req, flush_pc,
      output stall, flush, new_pc, div_start, div_cancel, div_timeout
   );
`endif
endinterface

`default_nettype wire

// File: rtl/stall_sched_wdog.sv
// ---------------------------------------------------------------------------
// stall_sched_wdog : divider wait counter with sticky timeout flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stall_sched_wdog #(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 7
)(
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o,
   output logic timeout_o
);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;

   assign expire_o  = enable_i && (cnt_q == CNT_W'(MAX_WAIT - 1));
   assign timeout_o = timeout_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (clear_i)
            cnt_q <= '0;
         else if (enable_i)
            cnt_q <= cnt_q + 1'b1;
         if (expire_o)
            timeout_q <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stall_sched.sv
// ---------------------------------------------------------------------------
// stall_sched : merges load-use, divider and flush hazards into stall/flush
// Rev 1.0   (optional perf counters: STALL_SCHED_PERF_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module stall_sched
   import stall_sched_pkg::*;
#(
   parameter int STALL_W  = 6,
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 7
)(
   input  logic          clk,
   input  logic          rst,
   stall_sched_if.slave  bus
);
   logic [1:0]         state_q, state_d;
   logic [STALL_W-1:0] stall_w;
   logic               start_w, cancel_w;
   logic               clear_w, enable_w, expire_w, timeout_w;

   assign clear_w  = (state_q == ST_IDLE) && bus.div_req && !bus.flush_req;
   assign enable_w = (state_q == ST_BUSY) && !bus.flush_req && !bus.div_ready;

   stall_sched_wdog #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear_w),
      .enable_i  (enable_w),
      .expire_o  (expire_w),
      .timeout_o (timeout_w)
   );

   always_comb begin
      state_d  = state_q;
      stall_w  = STALL_W'(STALL_NONE);
      start_w  = 1'b0;
      cancel_w = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.flush_req) begin
               if (bus.div_req) begin
                  start_w = 1'b1;
                  stall_w = STALL_W'(STALL_EX);
                  state_d = ST_BUSY;
               end else if (bus.stallreq_for_load) begin
                  stall_w = STALL_W'(STALL_LOAD);
               end
            end
         end
         ST_BUSY: begin
            if (bus.flush_req) begin
               cancel_w = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               stall_w = STALL_W'(STALL_EX);
               if (bus.div_ready || expire_w)
                  state_d = ST_DONE;
            end
         end
         // One free cycle lets EX capture the quotient; div_req is stale here.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Outputs go quiet the instant reset asserts, without waiting for clk.
   assign bus.stall       = rst ? stall_w : '0;
   assign bus.div_start   = rst && start_w;
   assign bus.div_cancel  = rst && cancel_w;
   assign bus.flush       = rst && bus.flush_req;
   assign bus.new_pc      = (rst && bus.flush_req) ? bus.flush_pc : 32'h0;
   assign bus.div_timeout = timeout_w;

`ifdef STALL_SCHED_PERF_EN
   logic [31:0] perf_load_q, perf_div_q, perf_flush_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_load_q  <= '0;
         perf_div_q   <= '0;
         perf_flush_q <= '0;
      end else begin
         if (bus.stall == STALL_W'(STALL_LOAD) && perf_load_q != '1)
            perf_load_q <= perf_load_q + 1'b1;
         if (bus.stall == STALL_W'(STALL_EX) && perf_div_q != '1)
            perf_div_q <= perf_div_q + 1'b1;
         if (bus.flush && perf_flush_q != '1)
            perf_flush_q <= perf_flush_q + 1'b1;
      end
   end

   assign bus.perf_load_stall = perf_load_q;
   assign bus.perf_div_stall  = perf_div_q;
   assign bus.perf_flush      = perf_flush_q;
`endif

endmodule

`default_nettype wire
